// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning and run/pause/lap/full sequencing for
// the stopwatch. Produces the centisecond tick enable, the counter clear
// pulse, the display freeze and the run/full LED.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 1_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk_50M,
  input  logic       clear_n,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       cnt_max,
  output logic       tick,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       LED,
  output logic [2:0] state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DBW      = $clog2(DB_CYCLES + 1);
  localparam int BW       = $clog2(BLINK_DIV + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LAP   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  // Button bit order throughout: [2]=stop, [1]=lap, [0]=start
  logic [2:0]     btn_raw;
  logic [2:0]     btn_p0;
  logic [2:0]     btn_p1;
  logic [2:0]     btn_level;
  logic [2:0]     btn_press;
  logic [DBW-1:0] db_cnt [3];

  logic [2:0]     state_q;
  logic [2:0]     state_d;
  logic           clr_d;
  logic [PW-1:0]  presc;
  logic           tick_cond;
  logic           ev_stop;
  logic           ev_lap;
  logic           ev_start;
  logic [BW-1:0]  blink_cnt;
  logic           blink_led;

  assign btn_raw = {stop, lap, start};

  // Synchroniser stage: two flops per asynchronous button input
  always_ff @(posedge clk_50M or negedge clear_n) begin
    if (!clear_n) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce stage: accept a new level after DB_CYCLES consecutive differing
  // samples; a rising acceptance emits a one-cycle press pulse
  always_ff @(posedge clk_50M or negedge clear_n) begin
    if (!clear_n) begin
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_p1[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= btn_p1[i];
          btn_press[i] <= btn_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the highest-priority press of a cycle is acted on: stop > lap > start
  assign ev_stop  = btn_press[2];
  assign ev_lap   = btn_press[1] & ~btn_press[2];
  assign ev_start = btn_press[0] & ~btn_press[1] & ~btn_press[2];

  assign tick_cond = ((state_q == S_RUN) || (state_q == S_LAP)) &&
                     (presc == PW'(TICK_DIV - 1));

  // State register plus the registered clear pulse for the time counter
  always_ff @(posedge clk_50M or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_clr <= clr_d;
    end
  end

  // Next-state logic; any entry into IDLE from another state clears the count
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ev_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_stop)                   state_d = S_PAUSE;
        else if (ev_lap)               state_d = S_LAP;
        else if (tick_cond && cnt_max) state_d = S_FULL;
      end
      S_LAP: begin
        if (ev_stop)                   state_d = S_PAUSE;
        else if (ev_lap)               state_d = S_RUN;
        else if (tick_cond && cnt_max) state_d = S_FULL;
      end
      S_PAUSE: begin
        if (ev_stop)       state_d = S_IDLE;
        else if (ev_start) state_d = S_RUN;
      end
      S_FULL: begin
        if (ev_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    clr_d = (state_d == S_IDLE) && (state_q != S_IDLE);
  end

  // Tick prescaler: runs in RUN/LAP, holds in PAUSE so resume keeps the phase
  always_ff @(posedge clk_50M or negedge clear_n) begin
    if (!clear_n) begin
      presc <= '0;
    end else begin
      case (state_q)
        S_RUN, S_LAP: presc <= tick_cond ? '0 : presc + 1'b1;
        S_PAUSE:      presc <= presc;
        default:      presc <= '0;
      endcase
    end
  end

  // FULL blink: LED starts lit on entry and toggles every BLINK_DIV cycles
  always_ff @(posedge clk_50M or negedge clear_n) begin
    if (!clear_n) begin
      blink_cnt <= '0;
      blink_led <= 1'b0;
    end else if (state_q == S_FULL) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_led <= ~blink_led;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink_led <= 1'b1;
    end
  end

  // Output decode; tick is suppressed at the maximum count so it never wraps
  always_comb begin
    tick      = tick_cond & ~cnt_max;
    disp_hold = (state_q == S_LAP);
    case (state_q)
      S_RUN, S_LAP: LED = 1'b1;
      S_FULL:       LED = blink_led;
      default:      LED = 1'b0;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with TICK_DIV=10,
// DB_CYCLES=4, BLINK_DIV=3. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_stopwatch_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LAP   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  // Button masks {stop, lap, start}
  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_LAP   = 3'b010;
  localparam logic [2:0] B_STOP  = 3'b100;

  logic       clk_50M = 1'b0;
  logic       clear_n;
  logic       start;
  logic       stop;
  logic       lap;
  logic       cnt_max;
  logic       tick;
  logic       cnt_clr;
  logic       disp_hold;
  logic       LED;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  stopwatch_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .DB_CYCLES(4),
    .BLINK_DIV(3)
  ) dut (
    .clk_50M  (clk_50M),
    .clear_n  (clear_n),
    .start    (start),
    .stop     (stop),
    .lap      (lap),
    .cnt_max  (cnt_max),
    .tick     (tick),
    .cnt_clr  (cnt_clr),
    .disp_hold(disp_hold),
    .LED      (LED),
    .state    (state)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_50M);
    cyc++;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic set_btn(input logic [2:0] m);
    {stop, lap, start} = m;
  endtask

  // Hold the buttons until the expected state appears (bounded), then release
  task automatic push(input logic [2:0] m, input logic [2:0] exp, input string tag);
    int k;
    k = 0;
    set_btn(m);
    do begin
      step();
      k++;
    end while (state !== exp && k < 30);
    set_btn(3'b000);
    chk(tag, int'(state), int'(exp));
  endtask

  // Steps until tick is seen; n = cycles stepped, or -1 if the bound expired
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < bound);
    if (tick !== 1'b1) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    int cnt;
    int moved;
    logic [6:0] pat;

    clear_n = 1'b0;
    cnt_max = 1'b0;
    set_btn(3'b000);

    // Reset values
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_disp_hold", int'(disp_hold), 0);
    chk("rst_led", int'(LED), 0);
    settle(2);
    clear_n = 1'b1;
    settle(3);
    chk("idle_after_rst", int'(state), int'(S_IDLE));

    // Bounce rejection: start toggled every 2 cycles, then held low
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      start = ((i / 2) % 2 == 0);
      step();
      if (state !== S_IDLE) moved = 1;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (state !== S_IDLE) moved = 1;
    end
    chk("bounce_no_press", moved, 0);

    // Clean start press
    push(B_START, S_RUN, "start_to_run");
    chk("run_led", int'(LED), 1);
    wait_tick(20, n);
    chk("first_tick_cycle", n + 1, 10);
    wait_tick(20, n);
    chk("tick_period_1", n, 10);
    step();
    chk("tick_one_cycle", int'(tick), 0);
    wait_tick(20, n);
    chk("tick_period_2", n + 1, 10);

    // Pause at prescaler 6: stop raised one cycle after a tick
    step();
    push(B_STOP, S_PAUSE, "stop_to_pause");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick === 1'b1) cnt++;
    end
    chk("pause_no_tick", cnt, 0);
    chk("pause_state", int'(state), int'(S_PAUSE));
    push(B_START, S_RUN, "resume");
    wait_tick(20, n);
    chk("resume_tick_cycle", n + 1, 3);

    // Pause then stop again: IDLE with a single clear pulse
    push(B_STOP, S_PAUSE, "stop2_to_pause");
    settle(10);
    push(B_STOP, S_IDLE, "pause_stop_idle");
    chk("clr_first_idle", int'(cnt_clr), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cnt_clr === 1'b1) cnt++;
    end
    chk("clr_single_cycle", cnt, 0);

    // Lap: display frozen, tick phase undisturbed
    push(B_START, S_RUN, "run_again");
    wait_tick(20, n);
    t0 = cyc;
    push(B_LAP, S_LAP, "lap_enter");
    chk("lap_hold", int'(disp_hold), 1);
    chk("lap_led", int'(LED), 1);
    wait_tick(20, n);
    chk("lap_phase", cyc - t0, 10);
    t0 = cyc;
    wait_tick(20, n);
    chk("lap_period", cyc - t0, 10);
    chk("lap_hold_kept", int'(disp_hold), 1);
    t0 = cyc;
    push(B_LAP, S_RUN, "lap_exit");
    chk("lap_exit_hold", int'(disp_hold), 0);
    wait_tick(20, n);
    chk("lap_exit_phase", cyc - t0, 10);

    // LAP then stop: PAUSE and display released
    settle(10);
    push(B_LAP, S_LAP, "lap_again");
    push(B_STOP, S_PAUSE, "lap_stop_pause");
    chk("lap_stop_hold", int'(disp_hold), 0);

    // Full: cnt_max at the tick boundary
    settle(10);
    push(B_START, S_RUN, "run_for_full");
    cnt_max = 1'b1;
    cnt = 0;
    n = 0;
    do begin
      step();
      n++;
      if (tick === 1'b1) cnt++;
    end while (state !== S_FULL && n < 20);
    chk("full_state", int'(state), int'(S_FULL));
    chk("full_no_tick", cnt, 0);
    pat[0] = LED;
    for (int i = 1; i < 7; i++) begin
      step();
      pat[i] = LED;
    end
    chk("full_blink", int'(pat), int'(7'b1000111));
    push(B_STOP, S_IDLE, "full_stop_idle");
    chk("full_clr", int'(cnt_clr), 1);
    cnt_max = 1'b0;

    // stop and lap together in RUN
    settle(10);
    push(B_START, S_RUN, "run_for_simul");
    settle(10);
    push(B_STOP | B_LAP, S_PAUSE, "stop_lap_simul");
    chk("simul_hold", int'(disp_hold), 0);

    // Asynchronous reset while in LAP
    settle(10);
    push(B_START, S_RUN, "run_for_rst");
    settle(10);
    push(B_LAP, S_LAP, "lap_for_rst");
    chk("lap_for_rst_hold", int'(disp_hold), 1);
    clear_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_hold", int'(disp_hold), 0);
    chk("async_rst_led", int'(LED), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_clr", int'(cnt_clr), 0);
    step();
    clear_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cnt_clr === 1'b1) cnt++;
    end
    chk("rst_no_clr", cnt, 0);
    chk("rst_stays_idle", int'(state), int'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
